// File: rtl/maze_feeder.sv
// Maze feeder: holds a 15x15 wall map, streams it bit-serially to the solver,
// then checks the solver's reply path against the stored map.
module maze_feeder #(
  parameter int N       = 15,
  parameter int TIMEOUT = 4096
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cfg_we,
  input  logic [3:0]   i_cfg_row,
  input  logic [N-1:0] i_cfg_data,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_in_valid,
  output logic         o_maze,
  input  logic         i_out_valid,
  input  logic         i_maze_not_valid,
  input  logic [3:0]   i_out_x,
  input  logic [3:0]   i_out_y,
  output logic         o_done,
  output logic [1:0]   o_result,
  output logic [7:0]   o_path_len
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [3:0] LAST = 4'(N - 1);
  localparam logic [3:0] GOAL = 4'(N - 2);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

  state_t        r_state;
  logic [N-1:0]  r_map [N];
  logic [3:0]    r_row, r_col, r_px, r_py;
  logic [CW-1:0] r_cnt;
  logic          r_busy, r_in_valid, r_maze, r_done;
  logic          r_first, r_nopath, r_err;
  logic [1:0]    r_result;
  logic [7:0]    r_path_len;

  logic          w_take, w_in_range, w_wall, w_step_ok, w_bad;
  logic [3:0]    w_dx, w_dy;
  logic [N-1:0]  w_row0;

  // A reply sample is only meaningful while waiting for or receiving the path.
  assign w_take     = i_out_valid && (r_state == S_WAIT || r_state == S_RECV);
  assign w_in_range = (i_out_x <= LAST) && (i_out_y <= LAST);
  assign w_wall     = w_in_range ? r_map[i_out_y][i_out_x] : 1'b1;
  assign w_dx       = (i_out_x >= r_px) ? (i_out_x - r_px) : (r_px - i_out_x);
  assign w_dy       = (i_out_y >= r_py) ? (i_out_y - r_py) : (r_py - i_out_y);
  assign w_step_ok  = (w_dx == 4'd1 && w_dy == 4'd0) || (w_dx == 4'd0 && w_dy == 4'd1);
  assign w_bad      = w_wall || (r_first ? (i_out_x != GOAL || i_out_y != GOAL) : !w_step_ok);
  // Bit 0 must see a row-0 write issued in the same cycle as start.
  assign w_row0     = (i_cfg_we && i_cfg_row == 4'd0) ? i_cfg_data : r_map[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < N; i++) r_map[i] <= '1;
      r_row      <= 4'd0;
      r_col      <= 4'd0;
      r_px       <= 4'd0;
      r_py       <= 4'd0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_in_valid <= 1'b0;
      r_maze     <= 1'b0;
      r_done     <= 1'b0;
      r_first    <= 1'b1;
      r_nopath   <= 1'b0;
      r_err      <= 1'b0;
      r_result   <= 2'd0;
      r_path_len <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cfg_we && i_cfg_row <= LAST) r_map[i_cfg_row] <= i_cfg_data;
          if (i_start) begin
            r_state    <= S_SEND;
            r_busy     <= 1'b1;
            r_in_valid <= 1'b1;
            r_maze     <= w_row0[0];
            r_row      <= 4'd0;
            r_col      <= 4'd0;
            r_path_len <= 8'd0;
            r_first    <= 1'b1;
            r_nopath   <= 1'b0;
            r_err      <= 1'b0;
          end
        end
        S_SEND: begin
          if (r_row == LAST && r_col == LAST) begin
            r_state    <= S_WAIT;
            r_in_valid <= 1'b0;
            r_maze     <= 1'b0;
            r_cnt      <= '0;
          end else if (r_col == LAST) begin
            r_row  <= r_row + 4'd1;
            r_col  <= 4'd0;
            r_maze <= r_map[r_row + 4'd1][0];
          end else begin
            r_col  <= r_col + 4'd1;
            r_maze <= r_map[r_row][r_col + 4'd1];
          end
        end
        S_WAIT: begin
          if (i_out_valid) begin
            r_state <= S_RECV;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= 2'd3;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RECV: begin
          if (!i_out_valid) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            if (r_nopath)                                    r_result <= 2'd1;
            else if (r_err || r_px != 4'd1 || r_py != 4'd1)  r_result <= 2'd2;
            else                                             r_result <= 2'd0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      // Once NO_PATH is flagged the remainder of the burst is dropped.
      if (w_take) begin
        r_first <= 1'b0;
        r_px    <= i_out_x;
        r_py    <= i_out_y;
        if (r_first && i_maze_not_valid) begin
          r_nopath <= 1'b1;
        end else if (!r_nopath) begin
          if (r_path_len != 8'hFF) r_path_len <= r_path_len + 8'd1;
          if (w_bad) r_err <= 1'b1;
        end
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_in_valid = r_in_valid;
  assign o_maze     = r_maze;
  assign o_done     = r_done;
  assign o_result   = r_result;
  assign o_path_len = r_path_len;

endmodule

// File: tb/tb_maze_feeder.sv
// Bench for maze_feeder: directed frames plus randomized mazes and reply paths,
// checked against a map/path reference model kept in the bench.
module tb_maze_feeder;
  localparam int N       = 15;
  localparam int TIMEOUT = 4096;

  logic         clk = 1'b0;
  logic         rst, cfg_we, start, out_valid, mnv;
  logic [3:0]   cfg_row, ox, oy;
  logic [N-1:0] cfg_data;
  logic         busy, in_valid, maze, done;
  logic [1:0]   result;
  logic [7:0]   path_len;

  int tests = 0;
  int fails = 0;

  logic [N-1:0] mrow [N];
  int sx[$];
  int sy[$];
  bit nmv_first;

  always #5 clk = ~clk;

  maze_feeder #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_cfg_we(cfg_we), .i_cfg_row(cfg_row),
    .i_cfg_data(cfg_data), .i_start(start), .o_busy(busy), .o_in_valid(in_valid),
    .o_maze(maze), .i_out_valid(out_valid), .i_maze_not_valid(mnv),
    .i_out_x(ox), .i_out_y(oy), .o_done(done), .o_result(result), .o_path_len(path_len)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_maze();
    for (int r = 0; r < N; r++)
      mrow[r] = (r == 0 || r == N - 1) ? '1 : {1'b1, {(N-2){1'b0}}, 1'b1};
  endtask

  task automatic random_maze();
    open_maze();
    for (int r = 1; r < N - 1; r++)
      mrow[r] = {1'b1, 13'($urandom) & 13'($urandom) & 13'($urandom), 1'b1};
    for (int c = 1; c < N - 1; c++) mrow[N-2][c] = 1'b0;
    for (int r = 1; r < N - 1; r++) mrow[r][1] = 1'b0;
  endtask

  task automatic load_map();
    for (int r = 0; r < N; r++) begin
      cfg_we = 1'b1; cfg_row = 4'(r); cfg_data = mrow[r];
      tick();
    end
    cfg_we = 1'b1; cfg_row = 4'd15; cfg_data = '0;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic make_staircase();
    sx.delete(); sy.delete();
    for (int x = N - 2; x >= 1; x--) begin sx.push_back(x); sy.push_back(N - 2); end
    for (int y = N - 3; y >= 1; y--) begin sx.push_back(1); sy.push_back(y); end
  endtask

  task automatic make_walk(input int len);
    int x, y;
    x = N - 2; y = N - 2;
    sx.delete(); sy.delete();
    for (int i = 0; i < len; i++) begin
      sx.push_back(x); sy.push_back(y);
      case ($urandom_range(0, 3))
        0:       x = (x + 1) % 16;
        1:       x = (x + 15) % 16;
        2:       y = (y + 1) % 16;
        default: y = (y + 15) % 16;
      endcase
    end
  endtask

  function automatic int ref_result();
    bit bad;
    int dx, dy, last;
    if (nmv_first) return 1;
    bad = (sx[0] != N - 2) || (sy[0] != N - 2);
    for (int i = 0; i < sx.size(); i++) begin
      if (sx[i] > N - 1 || sy[i] > N - 1) bad = 1'b1;
      else if (mrow[sy[i]][sx[i]] == 1'b1) bad = 1'b1;
      if (i > 0) begin
        dx = sx[i] - sx[i-1]; dy = sy[i] - sy[i-1];
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        if (dx + dy != 1) bad = 1'b1;
      end
    end
    last = sx.size() - 1;
    if (sx[last] != 1 || sy[last] != 1) bad = 1'b1;
    return bad ? 2 : 0;
  endfunction

  function automatic int ref_len();
    if (nmv_first) return 0;
    return (sx.size() > 255) ? 255 : sx.size();
  endfunction

  // Start a frame and capture the 225-bit stream; optional row-0 write with start,
  // optional write+start injection while the stream is running.
  task automatic send_phase(input int inject_k, input bit wr0, input logic [N-1:0] wr0_data,
                            output logic [224:0] got);
    logic [224:0] exp;
    int len;
    if (wr0) begin
      cfg_we = 1'b1; cfg_row = 4'd0; cfg_data = wr0_data; mrow[0] = wr0_data;
    end
    start = 1'b1;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    check("busy_after_start", busy, 1);
    for (int k = 0; k < 225; k++) exp[k] = mrow[k / N][k % N];
    got = '0; len = 0;
    for (int k = 0; k < 225; k++) begin
      got[k] = maze;
      if (in_valid) len++;
      if (k == inject_k) begin
        cfg_we = 1'b1; cfg_row = 4'd5; cfg_data = ~mrow[5]; start = 1'b1;
      end
      tick();
      cfg_we = 1'b0; start = 1'b0;
    end
    check("in_valid_len", len, 225);
    check("stream", got, exp);
    check("in_valid_after_send", in_valid, 0);
  endtask

  task automatic reply_check(input string tag);
    int n, exp_res, exp_len;
    bit early;
    n = sx.size(); early = 1'b0;
    exp_res = ref_result();
    exp_len = ref_len();
    for (int i = 0; i < n; i++) begin
      out_valid = 1'b1; ox = 4'(sx[i]); oy = 4'(sy[i]);
      mnv = (i == 0) ? nmv_first : 1'($urandom);
      tick();
      if (done) early = 1'b1;
    end
    out_valid = 1'b0; mnv = 1'b0;
    check({tag, "_no_early_done"}, early, 0);
    tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_path_len"}, path_len, exp_len);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [224:0] got;
    int n;
    rst = 1'b1; cfg_we = 1'b0; cfg_row = '0; cfg_data = '0; start = 1'b0;
    out_valid = 1'b0; mnv = 1'b0; ox = '0; oy = '0; nmv_first = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_in_valid", in_valid, 0);
    check("rst_maze", maze, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_path_len", path_len, 0);
    rst = 1'b0;
    tick();

    // Open corridor maze, clean 25-step path
    open_maze(); load_map();
    send_phase(-1, 1'b0, '0, got);
    check("t1_bit0", got[0], 1);
    check("t1_bit16", got[16], 0);
    make_staircase(); nmv_first = 1'b0;
    reply_check("t1");

    // Goal walled, solver reports no path for 3 cycles
    mrow[N-2][N-2] = 1'b1; load_map();
    send_phase(-1, 1'b0, '0, got);
    sx.delete(); sy.delete();
    for (int i = 0; i < 3; i++) begin sx.push_back(N - 2); sy.push_back(N - 2); end
    nmv_first = 1'b1;
    reply_check("t2");

    // Diagonal step in the path
    mrow[N-2][N-2] = 1'b0; load_map();
    send_phase(-1, 1'b0, '0, got);
    make_staircase(); sx[1] = 12; sy[1] = 12; nmv_first = 1'b0;
    reply_check("t3");

    // Silent solver
    send_phase(-1, 1'b0, '0, got);
    n = 0;
    while (!done && n < TIMEOUT + 100) begin tick(); n++; end
    check("t4_timeout_cycles", n, TIMEOUT);
    check("t4_result", result, 3);
    check("t4_path_len", path_len, 0);
    tick();
    check("t4_done_pulse", done, 0);
    check("t4_busy_low", busy, 0);

    // Reset in the middle of the stream
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    check("t5_bit100", maze, mrow[100 / N][100 % N]);
    rst = 1'b1; tick();
    check("t5_in_valid", in_valid, 0);
    check("t5_busy", busy, 0);
    rst = 1'b0;
    for (int r = 0; r < N; r++) mrow[r] = '1;
    send_phase(-1, 1'b0, '0, got);
    sx.delete(); sy.delete(); sx.push_back(N - 2); sy.push_back(N - 2);
    nmv_first = 1'b1;
    reply_check("t5a");
    open_maze(); load_map();
    send_phase(-1, 1'b0, '0, got);
    make_staircase(); nmv_first = 1'b0;
    reply_check("t5b");

    // Write and start while busy are ignored
    send_phase(50, 1'b0, '0, got);
    make_staircase(); nmv_first = 1'b0;
    reply_check("t6");
    tick(); tick();
    check("t6_no_new_frame", busy, 0);
    send_phase(-1, 1'b0, '0, got);
    reply_check("t6b");

    // Path length saturation
    send_phase(-1, 1'b0, '0, got);
    sx.delete(); sy.delete();
    for (int i = 0; i < 300; i++) begin sx.push_back((i % 2 == 0) ? 13 : 12); sy.push_back(13); end
    nmv_first = 1'b0;
    reply_check("sat");

    // Randomized mazes and replies
    for (int it = 0; it < 10; it++) begin
      int mode;
      random_maze(); load_map();
      send_phase(-1, 1'($urandom), N'($urandom), got);
      mode = $urandom_range(0, 3);
      nmv_first = 1'b0;
      case (mode)
        0: make_staircase();
        1: make_walk($urandom_range(2, 40));
        2: begin
          make_staircase();
          sx[$urandom_range(0, 24)] = $urandom_range(0, 15);
          sy[$urandom_range(0, 24)] = $urandom_range(0, 15);
        end
        default: begin
          make_walk($urandom_range(1, 6));
          nmv_first = 1'b1;
        end
      endcase
      reply_check($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
